// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and small helpers for the PS2 pad poll controller.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_START = 8'h01;
  localparam logic [7:0] PS2_CMD_POLL  = 8'h42;
  localparam logic [7:0] PS2_HDR_ACK   = 8'h5A;
  localparam logic [7:0] PS2_ID_DIG    = 8'h41;
  localparam logic [7:0] PS2_ID_ANA    = 8'h73;
  localparam logic [7:0] PS2_ID_ANA2   = 8'h79;
  localparam int         PS2_NBYTES    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } ps2_state_t;

  // Command bytes that do not depend on the rumble configuration
  function automatic logic [7:0] ps2_tx_base(input logic [3:0] idx);
    case (idx)
      4'd0:    return PS2_CMD_START;
      4'd1:    return PS2_CMD_POLL;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ps2_hdr_ok(input logic [7:0] id, input logic [7:0] ack);
    return (ack == PS2_HDR_ACK) &&
           ((id == PS2_ID_DIG) || (id == PS2_ID_ANA) || (id == PS2_ID_ANA2));
  endfunction

endpackage

// File: rtl/ps2_pad_poll_ctrl_if.sv
// Host-side (MMIO register file) signals of the PS2 pad poll controller.
// Motor inputs exist only when PS2_RUMBLE_EN is defined.
interface ps2_pad_poll_ctrl_if;
  logic        en;
  logic        req;
  logic        busy;
  logic [7:0]  pad_id;
  logic [15:0] pad_btn;
  logic [7:0]  pad_rx;
  logic [7:0]  pad_ry;
  logic [7:0]  pad_lx;
  logic [7:0]  pad_ly;
  logic        pad_valid;
  logic        pad_err;
`ifdef PS2_RUMBLE_EN
  logic        motor_sm;
  logic [7:0]  motor_lg;
`endif

  modport master (
    output en, req,
`ifdef PS2_RUMBLE_EN
    output motor_sm, motor_lg,
`endif
    input  busy, pad_id, pad_btn, pad_rx, pad_ry, pad_lx, pad_ly, pad_valid, pad_err
  );

  modport slave (
    input  en, req,
`ifdef PS2_RUMBLE_EN
    input  motor_sm, motor_lg,
`endif
    output busy, pad_id, pad_btn, pad_rx, pad_ry, pad_lx, pad_ly, pad_valid, pad_err
  );

endinterface

// File: rtl/ps2_spi_byte.sv
// Bit-level shifter for one pad byte: 8 spi_clk pulses, LSB first, 16*SCLK_HALF cycles.
module ps2_spi_byte #(
  parameter int SCLK_HALF = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic       done,
  output logic [7:0] rx,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int HW = $clog2(SCLK_HALF + 1);

  logic          active;
  logic [HW-1:0] hcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          half_end;

  assign half_end = (hcnt == '0);
  // done marks the last cycle of the final high half, so the caller can chain without a spare cycle
  assign done     = active && spi_clk && half_end && (bit_idx == 3'd7);
  assign rx       = rx_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      hcnt     <= '0;
      bit_idx  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      spi_clk  <= 1'b1;
      spi_mosi <= 1'b1;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        hcnt     <= HW'(SCLK_HALF - 1);
        bit_idx  <= 3'd0;
        tx_sh    <= tx;
        spi_clk  <= 1'b0;
        spi_mosi <= tx[0];
      end
    end else if (!half_end) begin
      hcnt <= hcnt - 1'b1;
    end else begin
      hcnt <= HW'(SCLK_HALF - 1);
      if (!spi_clk) begin
        spi_clk <= 1'b1;
        rx_sh   <= {spi_miso, rx_sh[7:1]};
      end else if (bit_idx == 3'd7) begin
        active   <= 1'b0;
        spi_mosi <= 1'b1;
      end else begin
        spi_clk  <= 1'b0;
        bit_idx  <= bit_idx + 3'd1;
        spi_mosi <= tx_sh[bit_idx + 3'd1];
      end
    end
  end

endmodule

// File: rtl/ps2_pad_poll_ctrl.sv
// PS2 gamepad poll sequencer: periodic/requested 9-byte exchanges, header check, atomic latch.
// Define PS2_RUMBLE_EN to send motor_sm/motor_lg in TX bytes 3 and 4.
module ps2_pad_poll_ctrl
  import ps2_pkg::*;
#(
  parameter int SCLK_HALF = 150,
  parameter int CS_SETUP  = 300,
  parameter int BYTE_GAP  = 600,
  parameter int POLL_CYC  = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_pad_poll_ctrl_if.slave   host,
  output logic                 spi_clk,
  output logic                 spi_cs,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int CW = $clog2(((CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP) + 1);
  localparam int PW = $clog2(POLL_CYC + 1);

  ps2_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] poll_cnt;
  logic [3:0]    byte_idx;
  logic [63:0]   shreg;
  logic          pending, tick, start, launch, busy_nxt, hdr_ok;
  logic          byte_start, byte_done;
  logic [7:0]    byte_rx, tx_sel;

  assign tick     = host.en && (poll_cnt == '0);
  assign start    = tick | host.req;
  assign busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
  assign hdr_ok   = ps2_hdr_ok(shreg[7:0], shreg[15:8]);

`ifdef PS2_RUMBLE_EN
  logic       motor_sm_q;
  logic [7:0] motor_lg_q;

  always_comb begin
    tx_sel = ps2_tx_base(byte_idx);
    if (byte_idx == 4'd3)      tx_sel = {7'b0, motor_sm_q};
    else if (byte_idx == 4'd4) tx_sel = motor_lg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_sm_q <= 1'b0;
      motor_lg_q <= 8'h00;
    end else if (launch) begin
      motor_sm_q <= host.motor_sm;
      motor_lg_q <= host.motor_lg;
    end
  end
`else
  assign tx_sel = ps2_tx_base(byte_idx);
`endif

  ps2_spi_byte #(.SCLK_HALF(SCLK_HALF)) u_byte (
    .clk      (clk),
    .rst      (rst),
    .start    (byte_start),
    .tx       (tx_sel),
    .done     (byte_done),
    .rx       (byte_rx),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // DONE may relaunch directly so a queued poll only drops busy for one cycle
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == '0) ? cnt : cnt - 1'b1;
    byte_start = 1'b0;
    launch     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start || pending) begin
          launch    = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = CW'(CS_SETUP - 1);
        end
      end
      ST_SETUP, ST_GAP: begin
        if (cnt == '0) begin
          byte_start = 1'b1;
          state_nxt  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (byte_done) begin
          if (byte_idx == 4'(PS2_NBYTES - 1)) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CW'(CS_SETUP - 1);
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = CW'(BYTE_GAP - 1);
          end
        end
      end
      ST_HOLD: begin
        if (cnt == '0) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shadow shift register keeps bytes 1..8 (byte 1 at [7:0]); outputs copy it only on a good header
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      poll_cnt       <= '0;
      byte_idx       <= 4'd0;
      shreg          <= 64'h0;
      pending        <= 1'b0;
      spi_cs         <= 1'b1;
      host.busy      <= 1'b0;
      host.pad_valid <= 1'b0;
      host.pad_err   <= 1'b0;
      host.pad_id    <= 8'h00;
      host.pad_btn   <= 16'hFFFF;
      host.pad_rx    <= 8'h00;
      host.pad_ry    <= 8'h00;
      host.pad_lx    <= 8'h00;
      host.pad_ly    <= 8'h00;
    end else begin
      cnt       <= cnt_nxt;
      host.busy <= busy_nxt;
      spi_cs    <= !busy_nxt;
      pending   <= launch ? 1'b0 : (pending | start);

      if (!host.en || (poll_cnt == '0)) poll_cnt <= PW'(POLL_CYC - 1);
      else                              poll_cnt <= poll_cnt - 1'b1;

      if (launch)         byte_idx <= 4'd0;
      else if (byte_done) byte_idx <= byte_idx + 4'd1;

      if (byte_done) shreg <= {byte_rx, shreg[63:8]};

      host.pad_valid <= 1'b0;
      host.pad_err   <= 1'b0;
      if (state == ST_DONE) begin
        if (hdr_ok) begin
          host.pad_valid <= 1'b1;
          host.pad_id    <= shreg[7:0];
          host.pad_btn   <= shreg[31:16];
          host.pad_rx    <= shreg[39:32];
          host.pad_ry    <= shreg[47:40];
          host.pad_lx    <= shreg[55:48];
          host.pad_ly    <= shreg[63:56];
        end else begin
          host.pad_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_pad_poll_ctrl.sv
// Self-checking bench for ps2_pad_poll_ctrl with a behavioural pad; small timing parameters.
module tb_ps2_pad_poll_ctrl;

  localparam int SCLK_HALF = 2;
  localparam int CS_SETUP  = 4;
  localparam int BYTE_GAP  = 6;
  localparam int POLL_CYC  = 600;
  localparam int TCLK      = 10;

`ifdef PS2_RUMBLE_EN
  localparam logic [7:0] EXP_B3 = 8'h01;
  localparam logic [7:0] EXP_B4 = 8'hC0;
`else
  localparam logic [7:0] EXP_B3 = 8'h00;
  localparam logic [7:0] EXP_B4 = 8'h00;
`endif

  typedef struct {
    logic [71:0] frame;
    logic        ok;
    logic [7:0]  id;
    logic [15:0] btn;
    logic [7:0]  rx, ry, lx, ly;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic spi_clk, spi_cs, spi_mosi;
  logic spi_miso = 1'b1;

  ps2_pad_poll_ctrl_if bus();

  ps2_pad_poll_ctrl #(
    .SCLK_HALF (SCLK_HALF),
    .CS_SETUP  (CS_SETUP),
    .BYTE_GAP  (BYTE_GAP),
    .POLL_CYC  (POLL_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (bus),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #(TCLK / 2) clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          cs_falls = 0;
  logic [71:0] cur_frame = 72'h0;
  int          pad_bi = 0, pad_bt = 0, mo_bi = 0, mo_bt = 0, n_sfall = 0;
  logic [7:0]  mosi_bytes [9];
  time         t_cs = 0, t_cs_prev = 0, t_f0 = 0, t_f1 = 0;
  vec_t        vecs [6];

  // Pad: presents MISO on spi_clk fall, captures MOSI on spi_clk rise
  initial begin
    logic p_cs, p_clk;
    p_cs  = 1'b1;
    p_clk = 1'b1;
    forever begin
      @(spi_cs or spi_clk);
      if ((spi_cs !== p_cs) && (spi_cs === 1'b0)) begin
        pad_bi = 0; pad_bt = 0; mo_bi = 0; mo_bt = 0; n_sfall = 0;
        for (int i = 0; i < 9; i++) mosi_bytes[i] = 8'h00;
        cs_falls++;
        t_cs_prev = t_cs;
        t_cs = $time;
      end
      if ((spi_clk !== p_clk) && (spi_cs === 1'b0)) begin
        if (spi_clk === 1'b0) begin
          if (n_sfall == 0) t_f0 = $time;
          if (n_sfall == 1) t_f1 = $time;
          n_sfall++;
          if (pad_bi < 9) spi_miso = cur_frame[64 - 8 * pad_bi + pad_bt];
          pad_bt++;
          if (pad_bt == 8) begin pad_bt = 0; pad_bi++; end
        end else if (mo_bi < 9) begin
          mosi_bytes[mo_bi][mo_bt] = spi_mosi;
          mo_bt++;
          if (mo_bt == 8) begin mo_bt = 0; mo_bi++; end
        end
      end
      p_cs  = spi_cs;
      p_clk = spi_clk;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.pad_valid === 1'b1) valid_cnt++;
      if (bus.pad_err === 1'b1)   err_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic waitBusy(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    while ((bus.busy !== lvl) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, 32'(bus.busy === lvl), 32'd1);
  endtask

  task automatic pulseReq();
    @(posedge clk);
    #1 bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic applyStimulus(input logic [71:0] frame);
    cur_frame = frame;
    pulseReq();
    waitBusy(1'b1, 20, "busy_rise");
    waitBusy(1'b0, 1000, "busy_fall");
    repeat (3) @(negedge clk);
  endtask

  task automatic checkPad(input vec_t v);
    checkOutput("pad_id",  32'(bus.pad_id),  32'(v.id));
    checkOutput("pad_btn", 32'(bus.pad_btn), 32'(v.btn));
    checkOutput("pad_rx",  32'(bus.pad_rx),  32'(v.rx));
    checkOutput("pad_ry",  32'(bus.pad_ry),  32'(v.ry));
    checkOutput("pad_lx",  32'(bus.pad_lx),  32'(v.lx));
    checkOutput("pad_ly",  32'(bus.pad_ly),  32'(v.ly));
  endtask

  initial begin
    int base_cs, base_v, base_e, low_cyc;

    vecs[0] = '{72'hFF_41_5A_7F_BF_80_80_80_80, 1'b1, 8'h41, 16'hBF7F, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[1] = '{72'hFF_73_5A_12_34_01_02_03_04, 1'b1, 8'h73, 16'h3412, 8'h01, 8'h02, 8'h03, 8'h04};
    vecs[2] = '{72'hFF_79_5A_FE_FF_10_20_30_40, 1'b1, 8'h79, 16'hFFFE, 8'h10, 8'h20, 8'h30, 8'h40};
    vecs[3] = '{72'hFF_41_00_00_00_11_22_33_44, 1'b0, 8'h79, 16'hFFFE, 8'h10, 8'h20, 8'h30, 8'h40};
    vecs[4] = '{72'hFF_42_5A_00_00_55_66_77_88, 1'b0, 8'h79, 16'hFFFE, 8'h10, 8'h20, 8'h30, 8'h40};
    vecs[5] = '{72'hFF_41_5A_AA_55_C3_3C_5A_A5, 1'b1, 8'h41, 16'h55AA, 8'hC3, 8'h3C, 8'h5A, 8'hA5};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.req = 1'b0;
`ifdef PS2_RUMBLE_EN
    bus.motor_sm = 1'b1;
    bus.motor_lg = 8'hC0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_cs",    32'(spi_cs),        32'd1);
    checkOutput("rst_sclk",  32'(spi_clk),       32'd1);
    checkOutput("rst_mosi",  32'(spi_mosi),      32'd1);
    checkOutput("rst_busy",  32'(bus.busy),      32'd0);
    checkOutput("rst_valid", 32'(bus.pad_valid), 32'd0);
    checkOutput("rst_err",   32'(bus.pad_err),   32'd0);
    checkOutput("rst_btn",   32'(bus.pad_btn),   32'hFFFF);
    checkOutput("rst_ly",    32'(bus.pad_ly),    32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      base_v = valid_cnt;
      base_e = err_cnt;
      applyStimulus(vecs[i].frame);
      checkOutput("valid_pulses", 32'(valid_cnt - base_v), 32'(vecs[i].ok));
      checkOutput("err_pulses",   32'(err_cnt - base_e),   32'(!vecs[i].ok));
      checkPad(vecs[i]);
    end
    checkOutput("mosi_b0", 32'(mosi_bytes[0]), 32'h01);
    checkOutput("mosi_b1", 32'(mosi_bytes[1]), 32'h42);
    checkOutput("mosi_b3", 32'(mosi_bytes[3]), 32'(EXP_B3));
    checkOutput("mosi_b4", 32'(mosi_bytes[4]), 32'(EXP_B4));
    checkOutput("mosi_b8", 32'(mosi_bytes[8]), 32'h00);
    checkOutput("sclk_period", 32'(int'(t_f1 - t_f0)), 32'(2 * SCLK_HALF * TCLK));
    checkOutput("cs_setup",    32'(int'(t_f0 - t_cs)), 32'(CS_SETUP * TCLK));

    $display("[TB] requests during busy");
    base_cs = cs_falls;
    base_v = valid_cnt;
    cur_frame = vecs[2].frame;
    pulseReq();
    waitBusy(1'b1, 20, "q_busy_rise");
    for (int r = 0; r < 3; r++) begin
      repeat (20) @(posedge clk);
      #1 bus.req = 1'b1;
      @(posedge clk);
      #1 bus.req = 1'b0;
    end
    waitBusy(1'b0, 1000, "q_busy_fall");
    low_cyc = 0;
    while ((bus.busy !== 1'b1) && (low_cyc < 10)) begin
      @(negedge clk);
      low_cyc++;
    end
    checkOutput("q_busy_low_cycles", 32'(low_cyc), 32'd1);
    waitBusy(1'b0, 1000, "q_busy_fall2");
    repeat (400) @(negedge clk);
    checkOutput("q_transactions", 32'(cs_falls - base_cs), 32'd2);
    checkOutput("q_valid_pulses", 32'(valid_cnt - base_v), 32'd2);

    $display("[TB] simultaneous tick and req, periodic polling");
    cur_frame = vecs[0].frame;
    base_cs = cs_falls;
    base_v = valid_cnt;
    @(posedge clk);
    #1 bus.en = 1'b1;
    repeat (POLL_CYC - 1) @(posedge clk);
    #1 bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (450) @(negedge clk);
    checkOutput("tr_transactions", 32'(cs_falls - base_cs), 32'd1);
    checkOutput("tr_valid_pulses", 32'(valid_cnt - base_v), 32'd1);
    waitBusy(1'b1, 300, "poll_busy_rise");
    checkOutput("poll_period", 32'(int'(t_cs - t_cs_prev)), 32'(POLL_CYC * TCLK));
    waitBusy(1'b0, 1000, "poll_busy_fall");
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    checkPad(vecs[0]);

    $display("[TB] reset mid-transaction");
    cur_frame = vecs[1].frame;
    pulseReq();
    for (int k = 0; k < 2000; k++) begin
      if ((pad_bi == 4) && (pad_bt == 4)) break;
      @(negedge clk);
    end
    checkOutput("r_reached_b4", 32'((pad_bi == 4) && (pad_bt == 4)), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("r_cs",   32'(spi_cs),      32'd1);
    checkOutput("r_sclk", 32'(spi_clk),     32'd1);
    checkOutput("r_busy", 32'(bus.busy),    32'd0);
    checkOutput("r_btn",  32'(bus.pad_btn), 32'hFFFF);
    checkOutput("r_id",   32'(bus.pad_id),  32'h00);
    checkOutput("r_lx",   32'(bus.pad_lx),  32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    base_v = valid_cnt;
    applyStimulus(vecs[1].frame);
    checkOutput("r_mosi_b0", 32'(mosi_bytes[0]), 32'h01);
    checkOutput("r_mosi_b1", 32'(mosi_bytes[1]), 32'h42);
    checkOutput("r_valid",   32'(valid_cnt - base_v), 32'd1);
    checkPad(vecs[1]);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
